// File: rtl/repl_refill_pkg.sv
// Shared types and width helpers for the miss-handling / refill controller.
//   refill_state_t : controller FSM states
//   way_w()        : index width for a given associativity (min 1 bit)
//   word_w()       : word-offset width for a given line length (min 1 bit)
package repl_refill_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        WB,
        RD_REQ,
        REFILL,
        DONE
    } refill_state_t;

    function automatic int way_w(input int ways);
        return (ways < 2) ? 1 : $clog2(ways);
    endfunction

    function automatic int word_w(input int words);
        return (words < 2) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/repl_refill_ctrl_burst_cnt.sv
// Beat counter shared by the write-back and refill phases.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : return count to 0 (wins over inc)
//   inc        : advance by one, wrapping modulo LINE_WORDS
//   count      : current word offset
//   last       : count is at the final word of the line
module burst_cnt
    import repl_refill_pkg::*;
#(
    parameter int LINE_WORDS = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          inc,
    output logic [word_w(LINE_WORDS)-1:0] count,
    output logic                          last
);

    localparam int CNT_W = word_w(LINE_WORDS);

    // LINE_WORDS is a power of two, so natural overflow is the wrap.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == CNT_W'(LINE_WORDS - 1));

endmodule

// File: rtl/repl_refill_ctrl.sv
// Cache miss-handling controller: latches the policy's victim way, writes it
// back when dirty, refills it from memory, then pulses a policy update.
//   miss_req/miss_addr/miss_ack          : miss request from the cache
//   repl_index/repl_access/repl_update   : replacement-policy interface
//   victim_dirty/victim_tag/victim_line  : state of the victim way
//   wb_*                                 : write-back beat stream
//   rd_*                                 : refill read request
//   mem_rvalid/mem_rdata/mem_rlast       : refill data beats
//   fill_*                               : data-array write port
module repl_refill_ctrl
    import repl_refill_pkg::*;
#(
    parameter int SET_ASSOC  = 4,
    parameter int LINE_WORDS = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 20
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             miss_req,
    input  logic [ADDR_WIDTH-1:0]            miss_addr,
    output logic                             miss_ack,
    input  logic [$clog2(SET_ASSOC)-1:0]     repl_index,
    output logic [SET_ASSOC-1:0]             repl_access,
    output logic                             repl_update,
    input  logic                             victim_dirty,
    input  logic [TAG_WIDTH-1:0]             victim_tag,
    input  logic [LINE_WORDS*DATA_WIDTH-1:0] victim_line,
    output logic                             wb_valid,
    input  logic                             wb_ready,
    output logic [ADDR_WIDTH-1:0]            wb_addr,
    output logic [DATA_WIDTH-1:0]            wb_data,
    output logic                             wb_last,
    output logic                             rd_valid,
    input  logic                             rd_ready,
    output logic [ADDR_WIDTH-1:0]            rd_addr,
    input  logic                             mem_rvalid,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    input  logic                             mem_rlast,
    output logic                             fill_we,
    output logic [$clog2(SET_ASSOC)-1:0]     fill_way,
    output logic [$clog2(LINE_WORDS)-1:0]    fill_word,
    output logic [DATA_WIDTH-1:0]            fill_data
);

    localparam int WAY_W  = way_w(SET_ASSOC);
    localparam int WORD_W = word_w(LINE_WORDS);
    localparam int OFF_W  = $clog2(LINE_WORDS * DATA_WIDTH / 8);
    localparam int IDX_W  = ADDR_WIDTH - TAG_WIDTH - OFF_W;

    refill_state_t                   state;
    logic [ADDR_WIDTH-1:OFF_W]       addr_q;
    logic [WAY_W-1:0]                way_q;
    logic [TAG_WIDTH-1:0]            tag_q;
    logic [LINE_WORDS*DATA_WIDTH-1:0] line_q;

    logic              cnt_clr;
    logic              cnt_inc;
    logic              cnt_last;
    logic [WORD_W-1:0] cnt;

    // Byte offset within the line never reaches memory.
    logic unused_offset;
    assign unused_offset = ^miss_addr[OFF_W-1:0];

    // Write-back advances on accepted beats, refill on every returned beat.
    assign cnt_inc = ((state == WB) && wb_ready) || ((state == REFILL) && mem_rvalid);
    // Cleared on entry to a transaction and after it, so a truncated refill
    // does not leave a stale offset behind.
    assign cnt_clr = (state == LATCH) || (state == DONE);

    burst_cnt #(
        .LINE_WORDS(LINE_WORDS)
    ) u_burst_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .count(cnt),
        .last (cnt_last)
    );

    // Miss address is captured on acceptance so a requester that drops
    // miss_req mid-transaction cannot disturb the addresses; the victim
    // way state is captured in LATCH and never looked at again.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_q      <= '0;
            way_q       <= '0;
            tag_q       <= '0;
            line_q      <= '0;
            wb_valid    <= 1'b0;
            rd_valid    <= 1'b0;
            repl_update <= 1'b0;
            miss_ack    <= 1'b0;
            repl_access <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_req) begin
                        addr_q <= miss_addr[ADDR_WIDTH-1:OFF_W];
                        state  <= LATCH;
                    end
                end
                LATCH: begin
                    way_q  <= repl_index;
                    tag_q  <= victim_tag;
                    line_q <= victim_line;
                    if (victim_dirty) begin
                        state    <= WB;
                        wb_valid <= 1'b1;
                    end else begin
                        state    <= RD_REQ;
                        rd_valid <= 1'b1;
                    end
                end
                WB: begin
                    if (wb_ready && cnt_last) begin
                        state    <= RD_REQ;
                        wb_valid <= 1'b0;
                        rd_valid <= 1'b1;
                    end
                end
                RD_REQ: begin
                    if (rd_ready) begin
                        state    <= REFILL;
                        rd_valid <= 1'b0;
                    end
                end
                REFILL: begin
                    if (mem_rvalid && mem_rlast) begin
                        state       <= DONE;
                        repl_update <= 1'b1;
                        miss_ack    <= 1'b1;
                        repl_access <= SET_ASSOC'(1) << way_q;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    repl_update <= 1'b0;
                    miss_ack    <= 1'b0;
                    repl_access <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wb_addr = {tag_q, addr_q[OFF_W +: IDX_W], {OFF_W{1'b0}}};
    assign wb_data = wb_valid ? line_q[int'(cnt)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign wb_last = wb_valid && cnt_last;
    assign rd_addr = {addr_q, {OFF_W{1'b0}}};

    // Refill beats are written straight through in the cycle they arrive.
    assign fill_we   = (state == REFILL) && mem_rvalid;
    assign fill_way  = way_q;
    assign fill_word = cnt;
    assign fill_data = fill_we ? mem_rdata : '0;

endmodule

// File: tb/tb_repl_refill_ctrl.sv
module tb_repl_refill_ctrl;

    localparam int SA = 4;
    localparam int LW = 8;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TW = 20;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             miss_req;
    logic [AW-1:0]    miss_addr;
    logic             miss_ack;
    logic [1:0]       repl_index;
    logic [SA-1:0]    repl_access;
    logic             repl_update;
    logic             victim_dirty;
    logic [TW-1:0]    victim_tag;
    logic [LW*DW-1:0] victim_line;
    logic             wb_valid;
    logic             wb_ready;
    logic [AW-1:0]    wb_addr;
    logic [DW-1:0]    wb_data;
    logic             wb_last;
    logic             rd_valid;
    logic             rd_ready;
    logic [AW-1:0]    rd_addr;
    logic             mem_rvalid;
    logic [DW-1:0]    mem_rdata;
    logic             mem_rlast;
    logic             fill_we;
    logic [1:0]       fill_way;
    logic [2:0]       fill_word;
    logic [DW-1:0]    fill_data;

    always #5 clk = ~clk;

    repl_refill_ctrl #(
        .SET_ASSOC(SA), .LINE_WORDS(LW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .miss_req(miss_req), .miss_addr(miss_addr), .miss_ack(miss_ack),
        .repl_index(repl_index), .repl_access(repl_access), .repl_update(repl_update),
        .victim_dirty(victim_dirty), .victim_tag(victim_tag), .victim_line(victim_line),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_last(wb_last),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast),
        .fill_we(fill_we), .fill_way(fill_way), .fill_word(fill_word), .fill_data(fill_data)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } wb_exp_t;

    typedef struct {
        logic [1:0]    way;
        logic [2:0]    word;
        logic [DW-1:0] data;
    } fill_exp_t;

    wb_exp_t       wb_q[$];
    logic [AW-1:0] rd_q[$];
    fill_exp_t     fill_q[$];
    logic [SA-1:0] done_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every DUT-presented transfer is matched against the oldest
    // expectation of its kind. Stalled write-back beats are checked against
    // the head without popping, which also proves the beat holds steady.
    always @(negedge clk) begin
        if (wb_valid) begin
            if (wb_q.size() == 0) chk("wb_unexpected", wb_valid, 0);
            else begin
                chk("wb_addr", wb_addr, wb_q[0].addr);
                chk("wb_data", wb_data, wb_q[0].data);
                chk("wb_last", wb_last, wb_q[0].last);
                if (wb_ready) void'(wb_q.pop_front());
            end
        end
        if (rd_valid) begin
            if (rd_q.size() == 0) chk("rd_unexpected", rd_valid, 0);
            else begin
                chk("rd_addr", rd_addr, rd_q[0]);
                if (rd_ready) void'(rd_q.pop_front());
            end
        end
        if (fill_we) begin
            if (fill_q.size() == 0) chk("fill_unexpected", fill_we, 0);
            else begin
                fill_exp_t f;
                f = fill_q.pop_front();
                chk("fill_way", fill_way, f.way);
                chk("fill_word", fill_word, f.word);
                chk("fill_data", fill_data, f.data);
            end
        end
        if (repl_update || miss_ack) begin
            chk("update_with_ack", {repl_update, miss_ack}, 2'b11);
            if (done_q.size() == 0) chk("update_unexpected", repl_update, 0);
            else chk("repl_access", repl_access, done_q.pop_front());
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_miss_ack"}, miss_ack, 0);
        chk({tag, "_repl_update"}, repl_update, 0);
        chk({tag, "_repl_access"}, repl_access, 0);
        chk({tag, "_wb_valid"}, wb_valid, 0);
        chk({tag, "_wb_last"}, wb_last, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_fill_we"}, fill_we, 0);
        chk({tag, "_addrs"}, {wb_addr, rd_addr}, 0);
        chk({tag, "_data"}, {wb_data, fill_data}, 0);
        chk({tag, "_fill_idx"}, {fill_way, fill_word}, 0);
    endtask

    task automatic chk_queues_empty(input string tag);
        chk({tag, "_wb_left"}, wb_q.size(), 0);
        chk({tag, "_rd_left"}, rd_q.size(), 0);
        chk({tag, "_fill_left"}, fill_q.size(), 0);
        chk({tag, "_done_left"}, done_q.size(), 0);
    endtask

    // One miss transaction. Called at posedge+1 of an IDLE cycle (cycle 0).
    // wb_mode: 0 always ready, 1 toggling 1,0,1.., 2 random.
    // abort_beat >= 0 pulls reset during that refill beat.
    task automatic do_miss(input logic [AW-1:0] addr, input logic [1:0] way, input logic dirty,
                           input logic [TW-1:0] tag, input int nbeats, input int wb_mode,
                           input bit fast, input bit drop_wb, input int abort_beat);
        logic [LW*DW-1:0] line;
        logic [DW-1:0]    rdat[LW];
        bit               done_flag, refill_on, hs, tog, aborted;
        int               sent, wb_hs, nf, exp_lat;
        for (int i = 0; i < LW; i++) begin
            line[i*DW +: DW] = $urandom;
            rdat[i] = $urandom;
        end
        if (dirty)
            for (int i = 0; i < LW; i++)
                wb_q.push_back('{addr: {tag, 12'h000} | (addr & 32'h0000_0FE0),
                                 data: line[i*DW +: DW], last: (i == LW - 1)});
        rd_q.push_back(addr & ~32'h1F);
        nf = (abort_beat >= 0) ? abort_beat + 1 : nbeats;
        for (int i = 0; i < nf; i++)
            fill_q.push_back('{way: way, word: 3'(i % LW), data: rdat[i]});
        if (abort_beat < 0) done_q.push_back(SA'(1) << way);
        exp_lat = 3 + nbeats + (dirty ? LW : 0);

        miss_req = 1'b1; miss_addr = addr; repl_index = way;
        victim_dirty = dirty; victim_tag = tag; victim_line = line;
        done_flag = 0; refill_on = 0; sent = 0; wb_hs = 0; tog = 1; aborted = 0;

        for (int cyc = 0; cyc < 300 && !done_flag; cyc++) begin
            if (cyc >= 2) begin
                repl_index   = way ^ 2'($urandom_range(1, 3));
                victim_dirty = 1'($urandom);
                victim_tag   = TW'($urandom);
                victim_line  = {LW{$urandom}};
            end
            if (wb_valid && wb_mode == 0) wb_ready = 1'b1;
            else if (wb_valid && wb_mode == 1) begin wb_ready = tog; tog = ~tog; end
            else wb_ready = 1'($urandom);
            rd_ready   = fast ? 1'b1 : 1'($urandom);
            mem_rvalid = 1'b0;
            mem_rlast  = 1'b0;
            mem_rdata  = $urandom;
            if (refill_on && sent < nbeats) begin
                mem_rvalid = fast ? 1'b1 : ($urandom_range(0, 3) != 0);
                if (mem_rvalid) begin
                    mem_rdata = rdat[sent];
                    mem_rlast = (sent == nbeats - 1);
                    if (sent == abort_beat) rst_n = 1'b0;
                end
            end
            @(negedge clk);
            hs = rd_valid && rd_ready;
            if (mem_rvalid) sent++;
            if (wb_valid && wb_ready) begin
                wb_hs++;
                if (drop_wb && wb_hs == 3) begin miss_req = 1'b0; miss_addr = $urandom; end
            end
            if (!rst_n) begin aborted = 1; done_flag = 1; end
            if (miss_ack) begin
                if (fast && wb_mode == 0) chk("ack_latency", cyc, exp_lat);
                miss_req = 1'b0; miss_addr = $urandom;
                done_flag = 1;
            end
            @(posedge clk); #1;
            if (hs) refill_on = 1;
        end
        mem_rvalid = 1'b0; mem_rlast = 1'b0; miss_req = 1'b0;
        chk("txn_finished", done_flag, 1);
        if (!done_flag) begin
            wb_q.delete(); rd_q.delete(); fill_q.delete(); done_q.delete();
        end
        if (aborted) begin
            rst_n = 1'b1;
            @(negedge clk);
            chk_outputs_zero("after_abort");
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk("abort_no_update", repl_update, 0);
            end
            @(posedge clk); #1;
        end
        chk_queues_empty("txn");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; miss_req = 1'b0; miss_addr = '0; repl_index = '0;
        victim_dirty = 1'b0; victim_tag = '0; victim_line = '0;
        wb_ready = 1'b0; rd_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rlast = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Stray handshakes while idle must do nothing.
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = 1'b1; mem_rlast = 1'($urandom); mem_rdata = $urandom;
            wb_ready = 1'b1; rd_ready = 1'b1;
            @(negedge clk);
            chk("stray_fill_we", fill_we, 0);
            chk("stray_valids", {wb_valid, rd_valid}, 0);
            @(posedge clk); #1;
        end
        mem_rvalid = 1'b0; mem_rlast = 1'b0;

        do_miss(32'h0000_1234, 2'd2, 1'b0, 20'h00000, 8, 0, 1, 0, -1);  // clean, ack at 11
        do_miss(32'h8765_4321, 2'd1, 1'b1, 20'hABCDE, 8, 1, 1, 0, -1);  // dirty, toggling ready
        do_miss(32'h0000_5A60, 2'd0, 1'b1, 20'h13579, 8, 0, 1, 0, -1);  // dirty, full speed
        do_miss(32'h0000_2040, 2'd3, 1'b0, 20'h00001, 6, 0, 1, 0, -1);  // early rlast on word 5
        do_miss(32'hCAFE_0F80, 2'd2, 1'b1, 20'hFEDCB, 8, 2, 0, 1, -1);  // miss_req dropped mid-WB
        do_miss(32'h0000_3300, 2'd1, 1'b0, 20'h00002, 8, 0, 1, 0, 4);   // reset during beat 4
        do_miss(32'h0000_3300, 2'd1, 1'b0, 20'h00002, 8, 0, 1, 0, -1);  // fresh miss after abort

        for (int t = 0; t < 40; t++) begin
            do_miss($urandom, 2'($urandom), 1'($urandom), TW'($urandom),
                    $urandom_range(1, LW), $urandom_range(0, 2), 1'($urandom),
                    1'($urandom), -1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
